// File: rtl/param_password_lock.sv
// Parameterised digit-sequence lock: programmable password, error counting and lockdown.
// Define ADMIN_UNLOCK_EN to let the ADMIN_CODE sequence release lockdown without a reset.
module param_password_lock #(
    parameter int unsigned                 DIGIT_W    = 4,
    parameter int unsigned                 PW_LEN     = 4,
    parameter int unsigned                 MAX_ERR    = 3,
    parameter logic [PW_LEN*DIGIT_W-1:0]   ADMIN_CODE = 16'h0129
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [DIGIT_W-1:0]             digit,
    input  logic                           digitValid,
    input  logic                           setMode,
    input  logic                           clear,
    output logic                           unlockLight,
    output logic                           errorLight,
    output logic                           warningLight,
    output logic [$clog2(MAX_ERR+1)-1:0]   errCount,
    output logic [2:0]                     dbgState
);

    localparam int unsigned IDX_W = $clog2(PW_LEN);
    localparam int unsigned ERR_W = $clog2(MAX_ERR + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PW_LEN - 1);
    localparam logic [ERR_W-1:0] MAX_CNT  = ERR_W'(MAX_ERR);

    if (PW_LEN < 2 || PW_LEN > 16) begin : gBadPwLen
        $error("param_password_lock: PW_LEN must be within 2..16");
    end
    if (MAX_ERR < 1) begin : gBadMaxErr
        $error("param_password_lock: MAX_ERR must be at least 1");
    end
    if ($bits(ADMIN_CODE) != PW_LEN * DIGIT_W) begin : gBadAdmin
        $error("param_password_lock: ADMIN_CODE width must be PW_LEN*DIGIT_W");
    end

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ENTER    = 3'd1,
        UNLOCKED = 3'd2,
        ERROR    = 3'd3,
        LOCKDOWN = 3'd4,
        SET      = 3'd5
    } state_t;

    state_t             state, stateNext;
    logic [IDX_W-1:0]   idx, idxNext;
    logic               mismatch, mismatchNext;
    logic               unlockNext, errorNext, warningNext;
    logic [ERR_W-1:0]   errNext, errInc;
    logic               digitBad;
    logic               shadowWr, commit;

    logic [DIGIT_W-1:0] password [PW_LEN];
    logic [DIGIT_W-1:0] shadow   [PW_LEN];

`ifdef ADMIN_UNLOCK_EN
    logic [IDX_W-1:0]   adminIdx, adminIdxNext;

    function automatic logic [DIGIT_W-1:0] adminDigit(input logic [IDX_W-1:0] i);
        return ADMIN_CODE[(PW_LEN - 1 - 32'(i)) * DIGIT_W +: DIGIT_W];
    endfunction
`endif

    assign dbgState = state;

    always_comb begin
        stateNext    = state;
        idxNext      = idx;
        mismatchNext = mismatch;
        unlockNext   = unlockLight;
        errorNext    = errorLight;
        warningNext  = warningLight;
        errNext      = errCount;
        shadowWr     = 1'b0;
        commit       = 1'b0;
        digitBad     = mismatch | (digit != password[idx]);
        errInc       = errCount + ERR_W'(1);
`ifdef ADMIN_UNLOCK_EN
        adminIdxNext = adminIdx;
`endif
        unique case (state)
            IDLE, UNLOCKED, ERROR: begin
                if (state == UNLOCKED && setMode && !digitValid) begin
                    stateNext  = SET;
                    idxNext    = '0;
                    unlockNext = 1'b0;
                end else if (digitValid && !clear) begin
                    stateNext    = ENTER;
                    idxNext      = IDX_W'(1);
                    mismatchNext = (digit != password[0]);
                    unlockNext   = 1'b0;
                    errorNext    = 1'b0;
                end
            end
            ENTER: begin
                if (clear) begin
                    stateNext    = IDLE;
                    idxNext      = '0;
                    mismatchNext = 1'b0;
                end else if (digitValid) begin
                    if (idx == LAST_IDX) begin
                        idxNext      = '0;
                        mismatchNext = 1'b0;
                        if (!digitBad) begin
                            stateNext  = UNLOCKED;
                            unlockNext = 1'b1;
                            errNext    = '0;
                        end else begin
                            errNext = errInc;
                            if (errInc == MAX_CNT) begin
                                stateNext   = LOCKDOWN;
                                warningNext = 1'b1;
                            end else begin
                                stateNext = ERROR;
                                errorNext = 1'b1;
                            end
                        end
                    end else begin
                        idxNext      = idx + IDX_W'(1);
                        mismatchNext = digitBad;
                    end
                end
            end
            SET: begin
                // Abort (clear or setMode released) outranks a digit arriving in the same cycle.
                if (clear || !setMode) begin
                    stateNext = IDLE;
                    idxNext   = '0;
                end else if (digitValid) begin
                    shadowWr = 1'b1;
                    if (idx == LAST_IDX) begin
                        commit    = 1'b1;
                        stateNext = IDLE;
                        idxNext   = '0;
                    end else begin
                        idxNext = idx + IDX_W'(1);
                    end
                end
            end
            LOCKDOWN: begin
                warningNext = 1'b1;
                unlockNext  = 1'b0;
                errorNext   = 1'b0;
                errNext     = MAX_CNT;
`ifdef ADMIN_UNLOCK_EN
                if (clear) begin
                    adminIdxNext = '0;
                end else if (digitValid) begin
                    if (digit == adminDigit(adminIdx)) begin
                        if (adminIdx == LAST_IDX) begin
                            stateNext    = IDLE;
                            adminIdxNext = '0;
                            warningNext  = 1'b0;
                            errNext      = '0;
                        end else begin
                            adminIdxNext = adminIdx + IDX_W'(1);
                        end
                    end else begin
                        // A broken match restarts with this digit treated as the first admin digit.
                        adminIdxNext = (digit == adminDigit('0)) ? IDX_W'(1) : '0;
                    end
                end
`endif
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= IDLE;
            idx          <= '0;
            mismatch     <= 1'b0;
            unlockLight  <= 1'b0;
            errorLight   <= 1'b0;
            warningLight <= 1'b0;
            errCount     <= '0;
            for (int unsigned i = 0; i < PW_LEN; i++) begin
                password[i] <= '0;
                shadow[i]   <= '0;
            end
        end else begin
            state        <= stateNext;
            idx          <= idxNext;
            mismatch     <= mismatchNext;
            unlockLight  <= unlockNext;
            errorLight   <= errorNext;
            warningLight <= warningNext;
            errCount     <= errNext;
            if (shadowWr) begin
                shadow[idx] <= digit;
            end
            // The final digit goes straight into the password alongside the earlier shadow digits.
            if (commit) begin
                for (int unsigned i = 0; i < PW_LEN; i++) begin
                    password[i] <= (IDX_W'(i) == idx) ? digit : shadow[i];
                end
            end
        end
    end

`ifdef ADMIN_UNLOCK_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            adminIdx <= '0;
        end else begin
            adminIdx <= adminIdxNext;
        end
    end
`endif

endmodule

// File: doc/param_password_lock.md
PARAM_PASSWORD_LOCK -- requirements
Module: param_password_lock

Interface
REQ-001 Parameter DIGIT_W, default 4: bits per entered digit.
REQ-002 Parameter PW_LEN, default 4, legal range 2..16: digits per password.
REQ-003 Parameter MAX_ERR, default 3, minimum 1: failed entries before lockdown.
REQ-004 Parameter ADMIN_CODE, width PW_LEN*DIGIT_W, default 16'h0129: admin sequence, first digit in the MSBs.
REQ-005 CLK  input  1  sole clock; all state changes on the rising edge.
REQ-006 RST  input  1  reset, asynchronous, active-high.
REQ-007 digit  input  DIGIT_W  entered digit value.
REQ-008 digitValid  input  1  digit is consumed on each rising edge where this is 1.
REQ-009 setMode  input  1  request to program a new password.
REQ-010 clear  input  1  abort the current entry or programming.
REQ-011 unlockLight  output  1  correct password entered.
REQ-012 errorLight  output  1  last entry wrong, not yet locked down.
REQ-013 warningLight  output  1  lockdown active.
REQ-014 errCount  output  $clog2(MAX_ERR+1)  consecutive failed entries.
REQ-015 dbgState  output  3  encoding IDLE=0, ENTER=1, UNLOCKED=2, ERROR=3, LOCKDOWN=4, SET=5.

Function
REQ-016 The block SHALL store PW_LEN digits in a password array and hold a shadow array of the same size for programming.
REQ-017 All outputs SHALL be registered; a light SHALL assert on the edge that consumes the final digit and SHALL be visible in the following cycle.
REQ-018 In IDLE, UNLOCKED or ERROR, an accepted digit SHALL enter ENTER with index 1, clear both lights, and record whether the digit mismatched password[0].
REQ-019 In ENTER, each accepted digit SHALL be compared with password[index]; the index increments and the mismatch flag is sticky.
REQ-020 On the PW_LEN-th digit with no mismatch, the block SHALL go to UNLOCKED, set unlockLight and clear errCount to 0.
REQ-021 On the PW_LEN-th digit with a mismatch, errCount SHALL increment; if the new value equals MAX_ERR the block SHALL go to LOCKDOWN, otherwise it SHALL go to ERROR with errorLight set.
REQ-022 In LOCKDOWN, warningLight SHALL be 1, unlockLight and errorLight SHALL be 0, and errCount SHALL hold MAX_ERR.
REQ-023 setMode SHALL be honoured only in UNLOCKED with digitValid=0; the block then goes to SET with index 0 and unlockLight cleared. setMode is ignored in every other state.
REQ-024 In SET, accepted digits SHALL write shadow[index]; on the PW_LEN-th digit the shadow SHALL be copied into the password array in one edge, then the block goes to IDLE.
REQ-025 If setMode drops in SET before commit, the block SHALL go to IDLE, discard the shadow and keep the old password.
REQ-026 clear in ENTER or SET SHALL return the block to IDLE, discard the partial entry and leave errCount unchanged.
REQ-027 If clear and digitValid are both 1, clear SHALL win and the digit SHALL be dropped.
REQ-028 digitValid held high for N cycles SHALL consume N digits; there is no edge detection.

Reset
REQ-029 RST SHALL force IDLE immediately, regardless of CLK, and clear all lights, errCount, the index, the mismatch flag and the admin index.
REQ-030 RST SHALL set the password and shadow arrays to all zeros; RST mid-entry or mid-SET discards all progress.
REQ-031 RST SHALL exit LOCKDOWN.

Configuration
REQ-032 With ADMIN_UNLOCK_EN defined, in LOCKDOWN the block SHALL match accepted digits against ADMIN_CODE in order.
REQ-033 With ADMIN_UNLOCK_EN defined, a full ADMIN_CODE match SHALL clear errCount and warningLight and move the block to IDLE. A mismatching digit SHALL restart the match and SHALL be re-evaluated as admin digit 0. clear SHALL reset the admin index.
REQ-034 Without ADMIN_UNLOCK_EN, LOCKDOWN SHALL be left only by RST, and no admin-matching logic SHALL be synthesised.

Verification
REQ-035 RST, then digits 0,0,0,0 -> unlockLight=1 one cycle after the 4th digit, errCount=0, dbgState=2.
REQ-036 Unlocked, setMode=1, digits 3,1,4,1 -> IDLE; then 3,1,4,1 -> unlockLight=1; then 0,0,0,0 -> errorLight=1, errCount=1.
REQ-037 Three wrong entries -> errorLight after the 1st and 2nd; after the 3rd warningLight=1, dbgState=4, errCount=3.
REQ-038 Lockdown with ADMIN_UNLOCK_EN, digits 0,0,1,2,9 -> IDLE after the 9, errCount=0. Without the macro the same stimulus -> warningLight stays 1.
REQ-039 SET after 2 digits, setMode dropped -> IDLE; the old password still unlocks.
REQ-040 ENTER after 2 digits with clear=1 and digitValid=1 in the same cycle -> IDLE, errCount unchanged; RST asserted between clock edges -> outputs clear with no edge.
